sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_pkg.sv | 14 +
 rtl/sw_debounce_if.sv | 14 +
 rtl/debounce_bit.sv | 43 ++++
 rtl/sw_debounce.sv | 59 +++++
 tb/tb_sw_debounce.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch debouncer.
package sw_pkg;

  localparam int WIDTH_DEF      = 2;
  localparam int CLK_FREQ       = 125_000_000;
  // 10 ms stable period at the nominal clock
  localparam int DEB_CYCLES_DEF = CLK_FREQ / 100;
  localparam int CNT_W          = 21;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side bundle: raw levels in, debounced levels and status out.
interface sw_debounce_if import sw_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] SW_IN;
  logic [WIDTH-1:0] SW;
  logic             SW_CHG;
  logic             SW_VALID;

  modport master (output SW_IN, input SW, input SW_CHG, input SW_VALID);
  modport slave  (input SW_IN, output SW, output SW_CHG, output SW_VALID);

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer, stability counter and output flop.
module debounce_bit import sw_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic sw_in,
  output logic sw,
  output logic chg
);

  localparam int            CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Any agreement with the current output restarts the stable period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      sw  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      if (s2 == sw) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Strobe on the expiry edge; registered by the parent with the other channels.
  assign chg = (s2 != sw) && (cnt == CNT_LAST);

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with change pulse and post-reset valid flag.
module sw_debounce import sw_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  sw_debounce_if.slave  bus
);

  localparam int            VW       = cnt_width(DEB_CYCLES + 2);
  localparam logic [VW-1:0] VLD_LAST = VW'(DEB_CYCLES + 1);

  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] chg;
  logic             sw_chg;
  logic             sw_valid;
  logic [VW-1:0]    vcnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_bit (
      .CLK   (CLK),
      .RST   (RST),
      .sw_in (bus.SW_IN[i]),
      .sw    (sw_q[i]),
      .chg   (chg[i])
    );
  end

  // Simultaneous channel updates merge into a single pulse aligned with SW.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= |chg;
    end
  end

  // Valid once a full synchronize-and-debounce latency has elapsed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vcnt     <= '0;
      sw_valid <= 1'b0;
    end else if (!sw_valid) begin
      if (vcnt == VLD_LAST) begin
        sw_valid <= 1'b1;
      end else begin
        vcnt <= vcnt + 1'b1;
      end
    end
  end

  assign bus.SW       = sw_q;
  assign bus.SW_CHG   = sw_chg;
  assign bus.SW_VALID = sw_valid;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEB_CYCLES=8: directed scenarios plus random bouncing.
module tb_sw_debounce;

  localparam int W   = 2;
  localparam int DEB = 8;
  localparam int LAT = DEB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH      (W),
    .DEB_CYCLES (DEB)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_pulse = 0;
  int n_bad = 0;

  // Reference: samples seen at each edge; an output bit flips once the
  // synchronized input has disagreed with it for DEB consecutive edges.
  logic [W-1:0] hist [LAT];
  logic [W-1:0] m_sw = '0;
  logic         m_chg = 1'b0;
  logic         m_valid = 1'b0;
  int           since = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [W-1:0] d);
    if (r) begin
      for (int p = 0; p < LAT; p++) hist[p] = '0;
      m_sw = '0;
      m_chg = 1'b0;
      m_valid = 1'b0;
      since = 0;
    end else begin
      m_chg = 1'b0;
      for (int ch = 0; ch < W; ch++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int p = 1; p <= DEB; p++)
          if (hist[p][ch] == m_sw[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_sw[ch] = ~m_sw[ch];
          m_chg = 1'b1;
        end
      end
      since++;
      if (since >= LAT) m_valid = 1'b1;
      for (int p = 0; p < LAT - 1; p++) hist[p] = hist[p+1];
      hist[LAT-1] = d;
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] d);
    rst = r;
    bus.SW_IN = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    chk("sw", 32'(bus.SW), 32'(m_sw));
    chk("sw_chg", 32'(bus.SW_CHG), 32'(m_chg));
    chk("sw_valid", 32'(bus.SW_VALID), 32'(m_valid));
    if (bus.SW_CHG === 1'b1) n_pulse++;
    if (bus.SW === 2'b00 || bus.SW === 2'b11) n_bad++;
  endtask

  task automatic hold(input logic [W-1:0] d, input int n);
    for (int k = 0; k < n; k++) step(1'b0, d);
  endtask

  initial begin
    int lat;
    for (int p = 0; p < LAT; p++) hist[p] = '0;
    bus.SW_IN = '0;

    // Reset and valid timing
    for (int k = 0; k < 3; k++) step(1'b1, 2'b00);
    hold(2'b00, LAT - 1);
    chk("valid_before", 32'(bus.SW_VALID), 32'd0);
    step(1'b0, 2'b00);
    chk("valid_after", 32'(bus.SW_VALID), 32'd1);

    // Clean 00 -> 01
    n_pulse = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b01);
      if (lat == 0 && bus.SW === 2'b01) lat = k;
    end
    chk("lat_01", 32'(lat), 32'(LAT));
    chk("pulses_01", 32'(n_pulse), 32'd1);

    // Back to 00, then a short glitch that must be rejected
    hold(2'b00, 14);
    n_pulse = 0;
    hold(2'b01, 5);
    hold(2'b00, 15);
    chk("glitch_sw", 32'(bus.SW), 32'd0);
    chk("pulses_glitch", 32'(n_pulse), 32'd0);

    // Bounce x3, then stay high
    n_pulse = 0;
    for (int b = 0; b < 3; b++) begin
      hold(2'b01, 3);
      hold(2'b00, 2);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b01);
      if (lat == 0 && bus.SW === 2'b01) lat = k;
    end
    chk("lat_bounce", 32'(lat), 32'(LAT));
    chk("pulses_bounce", 32'(n_pulse), 32'd1);

    // 01 -> 10 in one cycle: both bits swap on the same edge
    n_pulse = 0;
    n_bad = 0;
    hold(2'b10, 16);
    chk("swap_sw", 32'(bus.SW), 32'd2);
    chk("swap_pulses", 32'(n_pulse), 32'd1);
    chk("swap_partial", 32'(n_bad), 32'd0);

    // Reset with a pending count of 6
    step(1'b1, 2'b00);
    hold(2'b00, 12);
    hold(2'b01, DEB);
    step(1'b1, 2'b01);
    chk("rst_sw", 32'(bus.SW), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b01);
      if (lat == 0 && bus.SW === 2'b01) lat = k;
    end
    chk("lat_after_rst", 32'(lat), 32'(LAT));

    // Random bouncing with occasional reset
    for (int c = 0; c < 1500; ) begin
      logic [W-1:0] v;
      int len;
      bit r;
      v = W'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      r = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < len; j++) step(r && j == 0, v);
      c += len;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
